// File: rtl/fifo_async_pkg.sv
// Shared pointer helpers for both halves of the async FIFO (Gray conversion, pointer sizing).
`timescale 1ns/1ps
package fifo_async_pkg;

    localparam int MAX_PTR_WIDTH = 32;
    typedef logic [MAX_PTR_WIDTH-1:0] ptr_word_t;

    // One extra bit beyond the index distinguishes laps, so full and empty differ.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic ptr_word_t width_mask(input int width);
        return (ptr_word_t'(1) << width) - ptr_word_t'(1);
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t bin, input int width);
        ptr_word_t b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t gray, input int width);
        ptr_word_t g;
        ptr_word_t b;
        g = gray & width_mask(width);
        b = g;
        for (int i = 1; i < width; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_pointer_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
`timescale 1ns/1ps
module fifo_pointer_sync #(
    parameter int WIDTH = 4
) (
    input  logic             read_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_sync
);

    logic [WIDTH-1:0] sync_p0;

    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            sync_p0   <= '0;
            gray_sync <= '0;
        end else begin
            sync_p0   <= gray_in;
            gray_sync <= sync_p0;
        end
    end

endmodule

// File: rtl/fifo_read_controller.sv
// Read-domain half of the async FIFO: read pointers, empty detection and a one-word output stage.
// Define FIFO_READ_LEVEL_EN to add the registered read_level occupancy output.
`timescale 1ns/1ps
module fifo_read_controller
    import fifo_async_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int PTR_WIDTH  = ptr_width(DEPTH),
    localparam int ADDR_RAW   = $clog2(DATA_WIDTH * (DEPTH - 1)),
    localparam int ADDR_WIDTH = (ADDR_RAW > 0) ? ADDR_RAW : 1
) (
    input  logic                  read_clk,
    input  logic                  reset,
    input  logic [PTR_WIDTH-1:0]  write_pointer_gray,
    output logic [PTR_WIDTH-1:0]  read_pointer_gray,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef FIFO_READ_LEVEL_EN
    ,
    output logic [PTR_WIDTH-1:0]  read_level
`endif
);

    logic [PTR_WIDTH-1:0] read_ptr_bin;
    logic [PTR_WIDTH-1:0] read_ptr_next;
    logic [PTR_WIDTH-1:0] sync_write_gray;
    logic                 empty;
    logic                 load;

    fifo_pointer_sync #(
        .WIDTH(PTR_WIDTH)
    ) u_write_ptr_sync (
        .read_clk (read_clk),
        .reset    (reset),
        .gray_in  (write_pointer_gray),
        .gray_sync(sync_write_gray)
    );

    // Full-width Gray compare: the lap bit keeps a full memory from looking empty.
    assign empty         = (read_pointer_gray == sync_write_gray);
    assign load          = !empty && (!out_valid || out_ready);
    assign read_ptr_next = read_ptr_bin + PTR_WIDTH'(1);
    assign read_address  = ADDR_WIDTH'(read_ptr_bin[PTR_WIDTH-2:0]) * ADDR_WIDTH'(DATA_WIDTH);

    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            read_ptr_bin      <= '0;
            read_pointer_gray <= '0;
            out_data          <= '0;
            out_valid         <= 1'b0;
        end else if (load) begin
            read_ptr_bin      <= read_ptr_next;
            read_pointer_gray <= PTR_WIDTH'(bin2gray(ptr_word_t'(read_ptr_next), PTR_WIDTH));
            out_data          <= read_data;
            out_valid         <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid         <= 1'b0;
        end
    end

`ifdef FIFO_READ_LEVEL_EN
    // Words visible in memory that have not yet moved into the output stage.
    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            read_level <= '0;
        end else begin
            read_level <= PTR_WIDTH'(gray2bin(ptr_word_t'(sync_write_gray), PTR_WIDTH)) - read_ptr_bin;
        end
    end
`endif

endmodule
